load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  RV32I load/store front end between the CPU execute stage and mem_manager. Accepts one load or
//  store per instruction, checks alignment, builds byte enables and lane-shifted store data, drives
//  a held request to mem_manager until done, then returns sign/zero-extended load data.
//  Stalls the CPU for the whole access.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max REQ cycles before abort (used only with LSU_TIMEOUT_EN)
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   synchronous, active-high reset
//  memRead        in   1   CPU load request (level, held while stall=1)
//  memWrite       in   1   CPU store request (level, held while stall=1)
//  funct3         in   3   RV32I size/sign field
//  address_in     in   32  effective byte address
//  data_in_CPU    in   32  store data (rs2)
//  stall          out  1   CPU must hold its request/pipeline
//  data_out_CPU   out  32  extended load result, valid when load_valid=1
//  load_valid     out  1   one-cycle pulse: load complete
//  store_done     out  1   one-cycle pulse: store complete
//  misaligned     out  1   one-cycle pulse: misaligned address or illegal funct3
//  bus_error      out  1   one-cycle pulse: timeout abort (0 without LSU_TIMEOUT_EN)
//  mm_address     out  32  word address {address_in[31:2],2'b00}, held in REQ
//  mm_wdata       out  32  lane-replicated store data
//  mm_sel         out  4   byte enables
//  mm_read        out  1   read request, high through REQ
//  mm_write       out  1   write request, high through REQ
//  mm_rdata       in   32  read word from mem_manager
//  mm_done        in   1   access complete; sampled only in REQ
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 (data_out_CPU=0). rst in any state -> IDLE next edge,
//    in-flight request dropped, mm_done ignored.
//  - States: IDLE, REQ, RESP, ERR.
//  - IDLE: req = memRead|memWrite. Both high -> load wins. Bad = illegal funct3 (load 011/110/111,
//    store 011..111) or halfword with addr[0]=1 or word with addr[1:0]!=0. req&bad -> ERR;
//    req&!bad -> REQ; registers address, funct3, direction, wdata, sel at that edge.
//  - REQ: mm_read/mm_write high from registered copies; mm_done=1 -> RESP (mm_rdata captured,
//    extended, into data_out_CPU). mm_done high in the same cycle REQ is entered is valid.
//  - RESP: load_valid or store_done pulses; -> IDLE unconditionally (CPU request ignored).
//  - ERR: misaligned pulses; no mm request issued; -> IDLE.
//  - stall = (IDLE & req & !bad) | REQ. Low in RESP/ERR so CPU advances. Load latency = 2 cycles
//    after request + mm wait cycles.
//  - Stores: SB wdata={4{d[7:0]}}, sel=4'b0001<<a[1:0]; SH wdata={2{d[15:0]}}, sel=a[1]?1100:0011;
//    SW wdata=d, sel=1111. Loads: sel per same rule; lane = mm_rdata>>(8*a[1:0]);
//    LB/LH sign-extend, LBU/LHU zero-extend, LW pass through.
//  - data_out_CPU holds last load value until next load or reset.
// CONFIGURATION
//  LSU_TIMEOUT_EN defined: 8-bit-min counter (width $clog2(TIMEOUT_CYCLES+1)) cleared on REQ entry,
//    increments each REQ cycle without mm_done; reaching TIMEOUT_CYCLES -> IDLE, bus_error pulse,
//    no load_valid/store_done. mm_done on the expiry cycle wins (normal completion).
//  Undefined: REQ waits indefinitely; bus_error tied 0; no counter.
// STRUCTURE
//  lsu_pkg: lsu_state_t enum, funct3 constants (F3_B/H/W/BU/HU), mm_sel/extend helper functions.
//  Sub-module lsu_align: combinational store replicate + sel generation and load lane extract/extend.
//  Top: FSM, request registers, output registers, optional timeout counter.
// TESTING
//  1 LW addr 0x100, mm_done 3 cycles into REQ, rdata 0xDEADBEEF -> mm_sel 1111, load_valid 1 pulse,
//    data_out_CPU 0xDEADBEEF, stall high exactly 4 cycles.
//  2 LB addr 0x103, rdata 0x80_00_00_00 -> 0xFFFFFF80; LBU same -> 0x00000080; LHU 0x102 -> 0x00008000.
//  3 SH addr 0x202, d 0x1234ABCD -> mm_wdata 0xABCDABCD, mm_sel 1100, mm_write high until
//    mm_done, store_done pulse.
//  4 LW addr 0x101; SH addr 0x003; funct3 011 load -> misaligned pulse, mm_read/mm_write never high,
//    stall 0.
//  5 rst asserted in REQ then mm_done next cycle -> IDLE, no load_valid, outputs 0; memRead+memWrite
//    together -> read issued only.
//  6 LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8, mm_done never -> bus_error pulse after 8 REQ cycles,
//    back to IDLE; mm_done on 8th cycle -> load_valid, no bus_error.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the RV32I load/store unit: FSM state encoding,
// funct3 size/sign constants, byte-enable generation, load lane extract/extend
// and the legality/alignment check.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_ERR  = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte enables for an access of the size encoded in funct3 at byte offset a
  function automatic logic [3:0] lane_sel(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_B, F3_BU: lane_sel = 4'b0001 << a;
      F3_H, F3_HU: lane_sel = a[1] ? 4'b1100 : 4'b0011;
      default:     lane_sel = 4'b1111;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] word,
                                              input logic [1:0] a);
    logic [31:0] lane;
    lane = word >> {a, 3'b000};
    case (f3)
      F3_B:    load_extend = {{24{lane[7]}}, lane[7:0]};
      F3_H:    load_extend = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   load_extend = {24'b0, lane[7:0]};
      F3_HU:   load_extend = {16'b0, lane[15:0]};
      default: load_extend = lane;
    endcase
  endfunction

  // Illegal funct3 for the direction, or an address not aligned to the access size
  function automatic logic access_bad(input logic [2:0] f3, input logic is_load,
                                      input logic [1:0] a);
    logic bad_f3;
    if (is_load) bad_f3 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    else         bad_f3 = (f3 == 3'b011) || f3[2];
    access_bad = bad_f3 || ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for the load/store unit: store data replication and byte
// enables from the incoming request, load lane extraction/extension from the
// registered request and the returned memory word. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  sel_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  // Replicate the store operand across every lane it could land in
  always_comb begin
    case (st_funct3_i)
      F3_B:    st_wdata_o = {4{st_data_i[7:0]}};
      F3_H:    st_wdata_o = {2{st_data_i[15:0]}};
      default: st_wdata_o = st_data_i;
    endcase
  end

  assign sel_o     = lane_sel(st_funct3_i, st_addr_lo_i);
  assign ld_data_o = load_extend(ld_funct3_i, ld_rdata_i, ld_addr_lo_i);

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store front end. Checks the CPU request, holds a word-aligned
// request to mem_manager until mm_done, then pulses completion and returns
// extended load data. Optional REQ timeout abort: define LSU_TIMEOUT_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] address_in,
  input  logic [31:0] data_in_CPU,
  output logic        stall,
  output logic [31:0] data_out_CPU,
  output logic        load_valid,
  output logic        store_done,
  output logic        misaligned,
  output logic        bus_error,
  output logic [31:0] mm_address,
  output logic [31:0] mm_wdata,
  output logic [3:0]  mm_sel,
  output logic        mm_read,
  output logic        mm_write,
  input  logic [31:0] mm_rdata,
  input  logic        mm_done
);

  lsu_state_t  state_q, state_d;
  logic        req, bad, accept;
  logic        load_q;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;
  logic [3:0]  sel_q;
  logic [31:0] data_out_q;
  logic [31:0] wdata_w, ld_ext_w;
  logic [3:0]  sel_w;
  logic        timeout_w;
  logic        in_req;

  // A load wins when both request lines are high
  assign req    = memRead | memWrite;
  assign bad    = access_bad(funct3, memRead, address_in[1:0]);
  assign accept = (state_q == S_IDLE) && req && !bad;
  assign in_req = (state_q == S_REQ);

  lsu_align u_align (
    .st_funct3_i  (funct3),
    .st_addr_lo_i (address_in[1:0]),
    .st_data_i    (data_in_CPU),
    .st_wdata_o   (wdata_w),
    .sel_o        (sel_w),
    .ld_funct3_i  (f3_q),
    .ld_addr_lo_i (addr_q[1:0]),
    .ld_rdata_i   (mm_rdata),
    .ld_data_o    (ld_ext_w)
  );

  // Next-state logic; RESP and ERR always return to IDLE regardless of the CPU
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req) state_d = bad ? S_ERR : S_REQ;
      S_REQ: begin
        if (mm_done)        state_d = S_RESP;
        else if (timeout_w) state_d = S_IDLE;
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset drops any in-flight request
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Capture the accepted request; outputs are gated by state so these need no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      load_q  <= memRead;
      addr_q  <= address_in;
      f3_q    <= funct3;
      wdata_q <= wdata_w;
      sel_q   <= sel_w;
    end
  end

  // Load result register: updated only on load completion, held otherwise
  always_ff @(posedge clk) begin
    if (rst)                           data_out_q <= '0;
    else if (in_req && mm_done && load_q) data_out_q <= ld_ext_w;
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CntRaw = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W  = (CntRaw > 8) ? CntRaw : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count REQ cycles without mm_done; zero outside REQ so each request starts fresh
  always_comb begin
    cnt_d = cnt_q;
    if (!in_req)       cnt_d = '0;
    else if (!mm_done) cnt_d = cnt_q + 1'b1;
  end

  // Timeout counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Expiry on the last allowed REQ cycle; a simultaneous mm_done completes normally
  assign timeout_w = in_req && !mm_done && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_w = 1'b0;
`endif

  assign bus_error    = timeout_w;
  assign stall        = accept || in_req;
  assign mm_read      = in_req && load_q;
  assign mm_write     = in_req && !load_q;
  assign mm_address   = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mm_wdata     = (in_req && !load_q) ? wdata_q : 32'h0;
  assign mm_sel       = in_req ? sel_q : 4'h0;
  assign load_valid   = (state_q == S_RESP) && load_q;
  assign store_done   = (state_q == S_RESP) && !load_q;
  assign misaligned   = (state_q == S_ERR);
  assign data_out_CPU = data_out_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, random
// accesses against a byte-level reference model, reset and timeout sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead, memWrite;
  logic [2:0]  funct3;
  logic [31:0] address_in, data_in_CPU;
  logic        stall;
  logic [31:0] data_out_CPU;
  logic        load_valid, store_done, misaligned, bus_error;
  logic [31:0] mm_address, mm_wdata;
  logic [3:0]  mm_sel;
  logic        mm_read, mm_write;
  logic [31:0] mm_rdata;
  logic        mm_done;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_load = 32'h0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite), .funct3(funct3),
    .address_in(address_in), .data_in_CPU(data_in_CPU), .stall(stall),
    .data_out_CPU(data_out_CPU), .load_valid(load_valid), .store_done(store_done),
    .misaligned(misaligned), .bus_error(bus_error), .mm_address(mm_address),
    .mm_wdata(mm_wdata), .mm_sel(mm_sel), .mm_read(mm_read), .mm_write(mm_write),
    .mm_rdata(mm_rdata), .mm_done(mm_done)
  );

  typedef struct {
    logic rd; logic wr; logic [2:0] f3; logic [31:0] addr; logic [31:0] d; logic [31:0] rdata;
    int wt; int kind; logic [31:0] dout; logic [3:0] sel; logic [31:0] wdata; int stl;
  } vec_t;

  typedef struct {
    int stall_n; int rd_n; int wr_n; int lv_n; int sd_n; int mis_n; int be_n;
    logic [3:0] sel; logic [31:0] wdata; logic [31:0] addr; logic [31:0] dout;
    bit post_pulse; bit post_stall; bit timed_out; logic [31:0] post_dout;
  } obs_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Byte-level reference: size/sign from funct3, lanes from the byte offset
  function automatic void ref_model(input bit is_load, input logic [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] d,
                                    input logic [31:0] rdata, output bit bad,
                                    output logic [3:0] sel, output logic [31:0] wdata,
                                    output logic [31:0] dout);
    int size, off; bit sgn, legal; longint v;
    size = 4; sgn = 0; legal = 1; v = 0;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: begin size = 1; legal = is_load; end
      3'd5: begin size = 2; legal = is_load; end
      default: legal = 0;
    endcase
    off = int'(addr[1:0]);
    bad = !legal || ((off % size) != 0);
    sel = '0; wdata = '0; dout = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + size) sel[i] = 1'b1;
      wdata[8*i +: 8] = d[8*(i % size) +: 8];
    end
    if (!bad) begin
      for (int k = 0; k < size; k++) v = v + (longint'(rdata[8*(off+k) +: 8]) << (8*k));
      if (sgn && v >= (64'sd1 <<< (8*size-1))) v = v - (64'sd1 <<< (8*size));
      dout = v[31:0];
    end
  endfunction

  // Drive one CPU access and act as mem_manager, finishing wt cycles into REQ
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] d,
                         input logic [31:0] rdata, input int wt, output obs_t o);
    bit fin; int reqc;
    o = '{default: '0};
    fin = 0; reqc = 0;
    @(negedge clk);
    memRead = rd; memWrite = wr; funct3 = f3; address_in = addr;
    data_in_CPU = d; mm_rdata = rdata; mm_done = 1'b0;
    for (int c = 0; c < 64 && !fin; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (mm_read || mm_write) begin
        mm_done = (reqc == wt);
        reqc++;
        o.sel = mm_sel; o.wdata = mm_wdata; o.addr = mm_address;
      end else mm_done = 1'b0;
      if (mm_read)    o.rd_n++;
      if (mm_write)   o.wr_n++;
      if (stall)      o.stall_n++;
      if (load_valid) begin o.lv_n++; o.dout = data_out_CPU; end
      if (store_done) o.sd_n++;
      if (misaligned) o.mis_n++;
      if (bus_error)  o.be_n++;
      if (load_valid || store_done || misaligned || bus_error) fin = 1;
    end
    o.timed_out = !fin;
    @(negedge clk);
    memRead = 1'b0; memWrite = 1'b0; mm_done = 1'b0;
    #1;
    o.post_pulse = load_valid | store_done | misaligned | bus_error | mm_read | mm_write;
    o.post_stall = stall;
    o.post_dout  = data_out_CPU;
  endtask

  task automatic verify(input string nm, input obs_t o, input int kind, input int wt,
                        input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] wdata, input logic [31:0] dout, input int stl);
    chk({nm, "_bound"},    32'(o.timed_out), 32'h0);
    chk({nm, "_lvalid"},   32'(o.lv_n),  32'(kind == 0));
    chk({nm, "_sdone"},    32'(o.sd_n),  32'(kind == 1));
    chk({nm, "_misal"},    32'(o.mis_n), 32'(kind == 2));
    chk({nm, "_buserr"},   32'(o.be_n),  32'h0);
    chk({nm, "_stall"},    32'(o.stall_n), 32'(stl));
    chk({nm, "_rdcyc"},    32'(o.rd_n), 32'((kind == 0) ? wt + 1 : 0));
    chk({nm, "_wrcyc"},    32'(o.wr_n), 32'((kind == 1) ? wt + 1 : 0));
    if (kind != 2) begin
      chk({nm, "_sel"},  32'(o.sel), 32'(sel));
      chk({nm, "_addr"}, o.addr, {addr[31:2], 2'b00});
    end
    if (kind == 1) chk({nm, "_wdata"}, o.wdata, wdata);
    if (kind == 0) begin
      chk({nm, "_dout"}, o.dout, dout);
      last_load = dout;
    end
    chk({nm, "_post"},      32'(o.post_pulse), 32'h0);
    chk({nm, "_poststall"}, 32'(o.post_stall), 32'h0);
    chk({nm, "_hold"},      o.post_dout, last_load);
  endtask

  initial begin
    vec_t vt[$];
    obs_t o;
    rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; funct3 = 3'b0; address_in = '0;
    data_in_CPU = '0; mm_rdata = '0; mm_done = 1'b0;

    // rd wr f3 addr d rdata wt kind(0 ld,1 st,2 mis) dout sel wdata stall
    vt.push_back('{1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2, 0, 32'hDEADBEEF, 4'hF, 32'h0, 4});
    vt.push_back('{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80000000, 0, 0, 32'hFFFFFF80, 4'h8, 32'h0, 2});
    vt.push_back('{1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80000000, 0, 0, 32'h00000080, 4'h8, 32'h0, 2});
    vt.push_back('{1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80000000, 0, 0, 32'h00008000, 4'hC, 32'h0, 2});
    vt.push_back('{1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80000000, 1, 0, 32'hFFFF8000, 4'hC, 32'h0, 3});
    vt.push_back('{1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 0, 0, 32'h0000007F, 4'h2, 32'h0, 2});
    vt.push_back('{1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 1, 1, 32'h0, 4'hC, 32'hABCDABCD, 3});
    vt.push_back('{1'b0, 1'b1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 0, 1, 32'h0, 4'h2, 32'hA5A5A5A5, 2});
    vt.push_back('{1'b0, 1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 3, 1, 32'h0, 4'hF, 32'hCAFEF00D, 5});
    vt.push_back('{1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 2, 32'h0, 4'h0, 32'h0, 0});
    vt.push_back('{1'b0, 1'b1, 3'b001, 32'h003, 32'h0, 32'h0, 0, 2, 32'h0, 4'h0, 32'h0, 0});
    vt.push_back('{1'b1, 1'b0, 3'b011, 32'h000, 32'h0, 32'h0, 0, 2, 32'h0, 4'h0, 32'h0, 0});
    vt.push_back('{1'b0, 1'b1, 3'b100, 32'h000, 32'h0, 32'h0, 0, 2, 32'h0, 4'h0, 32'h0, 0});
    vt.push_back('{1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 2, 32'h0, 4'h0, 32'h0, 0});
    vt.push_back('{1'b1, 1'b1, 3'b010, 32'h010, 32'h99999999, 32'h11223344, 0, 0, 32'h11223344, 4'hF, 32'h0, 2});

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_dout", data_out_CPU, 32'h0);
    chk("rst_pulses", 32'({load_valid, store_done, misaligned, bus_error}), 32'h0);
    chk("rst_mm", 32'({mm_read, mm_write, mm_sel}), 32'h0);
    chk("rst_mmaddr", mm_address, 32'h0);
    chk("rst_mmwdata", mm_wdata, 32'h0);
    rst = 1'b0;

    foreach (vt[i]) begin
      run_txn(vt[i].rd, vt[i].wr, vt[i].f3, vt[i].addr, vt[i].d, vt[i].rdata, vt[i].wt, o);
      verify($sformatf("tbl%0d", i), o, vt[i].kind, vt[i].wt, vt[i].addr, vt[i].sel,
             vt[i].wdata, vt[i].dout, vt[i].stl);
    end

    // Random accesses against the reference model
    for (int n = 0; n < 60; n++) begin
      logic rd, wr; logic [2:0] f3; logic [31:0] addr, d, rdata, wdata, dout;
      logic [3:0] sel; bit bad; int wt, kind;
      rd = 1'($urandom); wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      f3 = 3'($urandom); addr = $urandom; d = $urandom; rdata = $urandom;
      wt = int'($urandom_range(0, 3));
      ref_model(rd, f3, addr, d, rdata, bad, sel, wdata, dout);
      kind = bad ? 2 : (rd ? 0 : 1);
      run_txn(rd, wr, f3, addr, d, rdata, wt, o);
      verify($sformatf("rnd%0d", n), o, kind, wt, addr, sel, wdata, dout, bad ? 0 : wt + 2);
    end

    // Reset while in REQ, then a stray mm_done: nothing completes
    @(negedge clk);
    memRead = 1'b1; memWrite = 1'b0; funct3 = 3'b010; address_in = 32'h300;
    mm_rdata = 32'h55AA55AA; mm_done = 1'b0;
    @(negedge clk); #1;
    chk("rstreq_inreq", 32'(mm_read), 32'h1);
    chk("rstreq_addr", mm_address, 32'h300);
    rst = 1'b1;
    @(negedge clk);
    memRead = 1'b0; rst = 1'b0; mm_done = 1'b1; #1;
    chk("rstreq_mmread", 32'(mm_read), 32'h0);
    chk("rstreq_stall", 32'(stall), 32'h0);
    chk("rstreq_dout", data_out_CPU, 32'h0);
    chk("rstreq_mmaddr", mm_address, 32'h0);
    @(negedge clk);
    mm_done = 1'b0; #1;
    chk("rstreq_lvalid", 32'(load_valid), 32'h0);
    chk("rstreq_dout2", data_out_CPU, 32'h0);
    last_load = 32'h0;

`ifdef LSU_TIMEOUT_EN
    // No mm_done: abort on the 8th REQ cycle
    run_txn(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h12345678, 100, o);
    chk("to_bound", 32'(o.timed_out), 32'h0);
    chk("to_buserr", 32'(o.be_n), 32'h1);
    chk("to_lvalid", 32'(o.lv_n), 32'h0);
    chk("to_rdcyc", 32'(o.rd_n), 32'd8);
    chk("to_stall", 32'(o.stall_n), 32'd9);
    chk("to_post", 32'(o.post_pulse), 32'h0);
    chk("to_dout", o.post_dout, 32'h0);
    // mm_done on the 8th cycle completes normally
    run_txn(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h12345678, 7, o);
    verify("to_done", o, 0, 7, 32'h400, 4'hF, 32'h0, 32'h12345678, 9);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
